// File: rtl/mem_stage_if.sv
// ============================================================================
// mem_stage_if
// Handshake, bus, SRAM read-data and forwarding signals around mem_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if #(
    parameter int ES_TO_MS_BUS_WD = 71,
    parameter int MS_TO_WS_BUS_WD = 70
);
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [31:0]                data_sram_rdata;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       ms_fwd_we;
    logic [4:0]                 ms_fwd_dest;
    logic [31:0]                ms_fwd_data;
    logic                       ms_fwd_is_load;

    // Surrounding pipeline (execute, SRAM, write-back, decode) side
    modport master (
        output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               ms_fwd_we, ms_fwd_dest, ms_fwd_data, ms_fwd_is_load
    );

    // Memory stage side
    modport slave (
        input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               ms_fwd_we, ms_fwd_dest, ms_fwd_data, ms_fwd_is_load
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage
// Pipeline memory stage: latches execute results, selects load data or ALU
// result, holds SRAM read data across write-back stalls, drives forwarding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 71,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic          clk,
    input  logic          reset,
    mem_stage_if.slave    ms_if
);

    localparam logic MS_READY_GO = 1'b1;

    logic                       ms_valid;
    logic                       ms_first;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q;
    logic [31:0]                rdata_buf;
    logic                       rdata_buf_vld;

    logic                       gr_we;
    logic                       load_op;
    logic [31:0]                alu_result;
    logic [31:0]                pc;
    logic [4:0]                 dest;
    logic [31:0]                final_result;
    logic                       ms_allowin;
    logic                       accept;
    logic                       fwd_we;
    logic [MS_TO_WS_BUS_WD-1:0] ws_bus;

    assign {gr_we, load_op, alu_result, pc, dest} = es_bus_q;

    assign ms_allowin = !ms_valid || (MS_READY_GO && ms_if.ws_allowin);
    assign accept     = ms_if.es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid      <= 1'b0;
            ms_first      <= 1'b0;
            es_bus_q      <= '0;
            rdata_buf     <= 32'h0;
            rdata_buf_vld <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= ms_if.es_to_ms_valid;
            end
            if (accept) begin
                es_bus_q      <= ms_if.es_to_ms_bus;
                ms_first      <= 1'b1;
                rdata_buf_vld <= 1'b0;
            end else begin
                ms_first <= 1'b0;
                // SRAM data is only valid for this load in its first cycle; keep it for the stall
                if (ms_valid && ms_first && load_op && !ms_if.ws_allowin) begin
                    rdata_buf     <= ms_if.data_sram_rdata;
                    rdata_buf_vld <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        final_result = alu_result;
        if (load_op) begin
            final_result = rdata_buf_vld ? rdata_buf : ms_if.data_sram_rdata;
        end
    end

    assign ws_bus = {gr_we, dest, final_result, pc};

    // Stale bus contents during a bubble are masked by ms_valid here
    assign fwd_we = ms_valid && gr_we && (dest != 5'd0);

    assign ms_if.ms_allowin     = ms_allowin;
    assign ms_if.ms_to_ws_valid = ms_valid && MS_READY_GO;
    assign ms_if.ms_to_ws_bus   = ws_bus;
    assign ms_if.ms_fwd_we      = fwd_we;
    assign ms_if.ms_fwd_dest    = fwd_we ? dest : 5'd0;
    assign ms_if.ms_fwd_data    = fwd_we ? final_result : 32'h0;
    assign ms_if.ms_fwd_is_load = fwd_we && load_op;

endmodule

`default_nettype wire
